// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction fetch handshake between fetch unit and unified memory
// Ports (signals):
//   mem_req    - fetch request, driven by the fetch unit (address is PCOut via the IorD mux)
//   mem_rvalid - read data valid, driven by memory
//   mem_rdata  - read data, driven by memory
// Modports: master = fetch unit side, slave = memory side.
interface pc_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction register and fetch handshake
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   fetch_start         - request a fetch at the current PC
//   mem                 - fetch handshake (mem_req / mem_rvalid / mem_rdata)
//   PCOut, IR           - registered program counter and instruction register
//   ir_valid            - registered one-cycle pulse while IR holds a freshly fetched word
//   fetch_busy          - fetch in flight (REQ or DONE)
//   PCWrite, PCWriteCond, Zero, PCSource, ALUResult, ALUOut - PC write controls and sources
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_INC     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_start,
    pc_fetch_unit_if.master       mem,
    output logic [ADDR_WIDTH-1:0] PCOut,
    output logic [DATA_WIDTH-1:0] IR,
    output logic                  ir_valid,
    output logic                  fetch_busy,
    input  logic                  PCWrite,
    input  logic                  PCWriteCond,
    input  logic                  Zero,
    input  logic [1:0]            PCSource,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] ALUOut
);
    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

    logic                  we;
    logic [ADDR_WIDTH-1:0] target;

    // Only the low address bits of the ALU sources ever reach the PC.
    logic unused_alu_bits;
    assign unused_alu_bits = ^{ALUResult[DATA_WIDTH-1:ADDR_WIDTH], ALUOut[DATA_WIDTH-1:ADDR_WIDTH]};

    // PCSource==3 suppresses the write entirely, whatever PCWrite/PCWriteCond say.
    assign we = (PCWrite | (PCWriteCond & Zero)) & (PCSource != 2'd3);

    always_comb begin
        target = pc_q;
        case (PCSource)
            2'd0:    target = ALUResult[ADDR_WIDTH-1:0];
            2'd1:    target = ALUOut[ADDR_WIDTH-1:0];
            2'd2:    target = ir_q[ADDR_WIDTH-1:0];
            default: target = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            IDLE: begin
                // A write here lands before REQ, so a same-cycle fetch uses the new PC.
                if (we) pc_d = target;
                if (fetch_start) state_d = REQ;
            end
            REQ: begin
                // PC must stay stable while mem_req is high: defer writes.
                if (we) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = target;
                end
                if (mem.mem_rvalid) begin
                    ir_d       = mem.mem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // A write in this very cycle is the latest one and therefore wins.
                if (we)          pc_d = target;
                else if (pend_q) pc_d = pend_tgt_q;
                else             pc_d = pc_q + INC;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req = (state_q == REQ);
    assign fetch_busy  = (state_q == REQ) || (state_q == DONE);
    assign PCOut       = pc_q;
    assign IR          = ir_q;
    assign ir_valid    = ir_valid_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [15:0] PCOut;
    logic [31:0] IR;
    logic        ir_valid;
    logic        fetch_busy;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        Zero;
    logic [1:0]  PCSource;
    logic [31:0] ALUResult;
    logic [31:0] ALUOut;

    int n_checks = 0;
    int n_fails  = 0;

    pc_fetch_unit_if #(.DATA_WIDTH(32)) mem_if ();

    pc_fetch_unit #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .RESET_PC  (16'h0000),
        .PC_INC    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_start(fetch_start),
        .mem        (mem_if.master),
        .PCOut      (PCOut),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .Zero       (Zero),
        .PCSource   (PCSource),
        .ALUResult  (ALUResult),
        .ALUOut     (ALUOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        fetch_start      = 1'b0;
        PCWrite          = 1'b0;
        PCWriteCond      = 1'b0;
        Zero             = 1'b0;
        PCSource         = 2'd3;
        ALUResult        = '0;
        ALUOut           = '0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;

        // Reset then idle
        tick(); tick();
        reset = 1'b0;
        chk("rst_pc", 32'(PCOut), 32'h0000);
        chk("rst_ir", IR, 32'h0);
        chk("rst_req", 32'(mem_if.mem_req), 32'h0);
        chk("rst_irv", 32'(ir_valid), 32'h0);
        chk("rst_busy", 32'(fetch_busy), 32'h0);

        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("idle_rvalid_ir", IR, 32'h0);
        chk("idle_rvalid_irv", 32'(ir_valid), 32'h0);

        // Zero-wait fetch
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("zw_req", 32'(mem_if.mem_req), 32'h1);
        chk("zw_busy", 32'(fetch_busy), 32'h1);
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h8C220004;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("zw_irv", 32'(ir_valid), 32'h1);
        chk("zw_ir", IR, 32'h8C220004);
        chk("zw_req_done", 32'(mem_if.mem_req), 32'h0);
        chk("zw_pc_done", 32'(PCOut), 32'h0000);
        tick();
        chk("zw_irv_end", 32'(ir_valid), 32'h0);
        chk("zw_pc_inc", 32'(PCOut), 32'h0001);
        chk("zw_busy_end", 32'(fetch_busy), 32'h0);

        // Wait-state fetch: three cycles without rvalid, data on the fourth REQ cycle
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", 32'(mem_if.mem_req), 32'h1);
            chk("ws_pc", 32'(PCOut), 32'h0001);
            chk("ws_irv", 32'(ir_valid), 32'h0);
            tick();
        end
        chk("ws_req4", 32'(mem_if.mem_req), 32'h1);
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00000040;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("ws_irv_pulse", 32'(ir_valid), 32'h1);
        chk("ws_ir", IR, 32'h00000040);
        chk("ws_req_off", 32'(mem_if.mem_req), 32'h0);
        tick();
        chk("ws_irv_once", 32'(ir_valid), 32'h0);
        chk("ws_pc_inc", 32'(PCOut), 32'h0002);

        // Branch in IDLE
        PCWriteCond = 1'b1; PCSource = 2'd1; ALUOut = 32'h00012345; Zero = 1'b1;
        tick();
        chk("br_taken", 32'(PCOut), 32'h2345);
        Zero = 1'b0; ALUOut = 32'h00000777;
        tick();
        chk("br_not_taken", 32'(PCOut), 32'h2345);
        PCWriteCond = 1'b0; PCWrite = 1'b1; PCSource = 2'd3; ALUResult = 32'h00001111;
        tick();
        chk("pcsrc3_nowrite", 32'(PCOut), 32'h2345);
        PCWriteCond = 1'b1; Zero = 1'b0; PCSource = 2'd0; ALUResult = 32'h00050100;
        tick();
        PCWrite = 1'b0; PCWriteCond = 1'b0; PCSource = 2'd3;
        chk("pcwrite_dominates", 32'(PCOut), 32'h0100);

        // Mid-fetch redirect: jump to IR[15:0]=0x0040 during REQ
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        PCWrite = 1'b1; PCSource = 2'd2;
        tick();
        PCWrite = 1'b0; PCSource = 2'd3;
        chk("rd_pc_hold", 32'(PCOut), 32'h0100);
        chk("rd_req", 32'(mem_if.mem_req), 32'h1);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("rd_pc_hold2", 32'(PCOut), 32'h0100);
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h12340000;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("rd_irv", 32'(ir_valid), 32'h1);
        chk("rd_pc_done", 32'(PCOut), 32'h0100);
        tick();
        chk("rd_pc_jump", 32'(PCOut), 32'h0040);
        chk("rd_idle", 32'(fetch_busy), 32'h0);
        tick();
        chk("rd_fs_ignored", 32'(mem_if.mem_req), 32'h0);

        // Same-cycle write and fetch_start in IDLE: fetch uses the new PC
        PCWrite = 1'b1; PCSource = 2'd0; ALUResult = 32'h00000033; fetch_start = 1'b1;
        tick();
        PCWrite = 1'b0; PCSource = 2'd3; fetch_start = 1'b0;
        chk("sc_pc", 32'(PCOut), 32'h0033);
        chk("sc_req", 32'(mem_if.mem_req), 32'h1);
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h0000ABCD;
        tick();
        mem_if.mem_rvalid = 1'b0;
        tick();
        chk("sc_pc_inc", 32'(PCOut), 32'h0034);

        // Wrap at all-ones
        PCWrite = 1'b1; PCSource = 2'd0; ALUResult = 32'h0000FFFF;
        tick();
        PCWrite = 1'b0; PCSource = 2'd3;
        chk("wr_pc_ffff", 32'(PCOut), 32'hFFFF);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00000001;
        tick();
        mem_if.mem_rvalid = 1'b0;
        tick();
        chk("wr_pc_wrap", 32'(PCOut), 32'h0000);

        // Reset during REQ, then a stale response
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("rm_req", 32'(mem_if.mem_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_req_off", 32'(mem_if.mem_req), 32'h0);
        chk("rm_busy", 32'(fetch_busy), 32'h0);
        chk("rm_ir", IR, 32'h0);
        chk("rm_pc", 32'(PCOut), 32'h0000);
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("rm_stale_irv", 32'(ir_valid), 32'h0);
        chk("rm_stale_ir", IR, 32'h0);
        chk("rm_stale_req", 32'(mem_if.mem_req), 32'h0);
        tick();
        chk("rm_stale_irv2", 32'(ir_valid), 32'h0);
        chk("rm_stale_pc", 32'(PCOut), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
